// File: rtl/echo_pkg.sv
// Shared definitions for the buffered echo block: output FSM state encoding.
// Imported by echo_buffered and echo_fifo_mem.
package echo_pkg;

    // ST_FIRST presents the first (or only) copy of the head word.
    // ST_SECOND presents the repeat copy of a dup word.
    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

endpackage

// File: rtl/echo_fifo_mem.sv
// Storage array for the echo FIFO: one synchronous write port and a
// combinational read port. The contents are deliberately not reset.
module echo_fifo_mem
    import echo_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/echo_buffered.sv
// Buffered echo: words from the say channel go through a DEPTH-entry FIFO and
// come back on the heard channel. Words tagged with say_dup are returned twice.
module echo_buffered
    import echo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             say_valid,
    output logic             say_ready,
    input  logic [WIDTH-1:0] say,
    input  logic             say_dup,
    output logic             heard_valid,
    input  logic             heard_ready,
    output logic [WIDTH-1:0] heard,
    output logic             heard_last,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_t           state;
    state_t           next_state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             handshake;
    logic             head_dup;
    logic [WIDTH:0]   mem_rdata;

    // Full and empty come from count alone, so pointer equality never matters.
    assign say_ready   = (count < FULL_CNT);
    assign heard_valid = (count != '0);
    assign push        = say_valid && say_ready;
    assign handshake   = heard_valid && heard_ready;
    assign {head_dup, heard} = mem_rdata;

    echo_fifo_mem #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({say_dup, say}),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= ST_FIRST;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            state <= next_state;
        end
    end

    // A dup head is handed out once without popping; the second handshake pops it.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        heard_last = 1'b1;
        case (state)
            ST_FIRST: begin
                heard_last = !head_dup;
                if (handshake) begin
                    if (head_dup) begin
                        next_state = ST_SECOND;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ST_SECOND: begin
                heard_last = 1'b1;
                if (handshake) begin
                    pop        = 1'b1;
                    next_state = ST_FIRST;
                end
            end
            default: begin
                next_state = ST_FIRST;
            end
        endcase
    end

endmodule

// File: tb/tb_echo_buffered.sv
// Self-checking bench for echo_buffered: directed scenarios plus a randomized
// run scored against a queue-based model of the expected heard beats.
module tb_echo_buffered;

    logic        clk;
    logic        rst;
    logic        say_valid;
    logic        say_ready;
    logic [31:0] say;
    logic        say_dup;
    logic        heard_valid;
    logic        heard_ready;
    logic [31:0] heard;
    logic        heard_last;
    logic [2:0]  count;

    logic        s8_valid;
    logic        s8_ready;
    logic [7:0]  s8_say;
    logic        s8_dup;
    logic        h8_valid;
    logic        h8_ready;
    logic [7:0]  h8_heard;
    logic        h8_last;
    logic [1:0]  c8_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: expected beats as {last, data}; words = number of stored words.
    logic [32:0] q_beats[$];
    int          words = 0;

    echo_buffered #(.WIDTH(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .say_valid   (say_valid),
        .say_ready   (say_ready),
        .say         (say),
        .say_dup     (say_dup),
        .heard_valid (heard_valid),
        .heard_ready (heard_ready),
        .heard       (heard),
        .heard_last  (heard_last),
        .count       (count)
    );

    echo_buffered #(.WIDTH(8), .DEPTH(2)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .say_valid   (s8_valid),
        .say_ready   (s8_ready),
        .say         (s8_say),
        .say_dup     (s8_dup),
        .heard_valid (h8_valid),
        .heard_ready (h8_ready),
        .heard       (h8_heard),
        .heard_last  (h8_last),
        .count       (c8_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation ran past time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic model_step(input bit push, input logic [31:0] d, input bit dup, input bit hs);
        logic [32:0] beat;
        if (hs) begin
            beat = q_beats.pop_front();
            if (beat[32]) words--;
        end
        if (push) begin
            if (dup) q_beats.push_back({1'b0, d});
            q_beats.push_back({1'b1, d});
            words++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        say_valid = 1'b0; heard_ready = 1'b0; say = '0; say_dup = 1'b0;
        s8_valid = 1'b0; h8_ready = 1'b0; s8_say = '0; s8_dup = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q_beats.delete();
        words = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        say_valid = 1'b0; heard_ready = 1'b0; say = '0; say_dup = 1'b0;
        s8_valid = 1'b0; h8_ready = 1'b0; s8_say = '0; s8_dup = 1'b0;
        #1;
        n_checks++;
        if ({heard_valid, say_ready, count} !== {1'b0, 1'b1, 3'd0})
            $display("[TB] FAIL reset_during: valid/ready/count=%b/%b/%0d, wanted 0/1/0", heard_valid, say_ready, count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        q_beats.delete();
        words = 0;
        @(negedge clk); #1;
        n_checks++;
        if ({heard_valid, say_ready, count} !== {1'b0, 1'b1, 3'd0})
            $display("[TB] FAIL reset_after: valid/ready/count=%b/%b/%0d, wanted 0/1/0", heard_valid, say_ready, count);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        say_valid = 1'b1; say = 32'hDEADBEEF; say_dup = 1'b0; heard_ready = 1'b1;
        #1;
        n_checks++;
        if (heard_valid !== 1'b0)
            $display("[TB] FAIL single_nobypass: heard_valid=%b, wanted 0", heard_valid);
        else n_pass++;
        @(negedge clk);
        say_valid = 1'b0;
        #1;
        n_checks++;
        if ({heard_valid, heard, heard_last, count} !== {1'b1, 32'hDEADBEEF, 1'b1, 3'd1})
            $display("[TB] FAIL single_out: valid=%b heard=%h last=%b count=%0d, wanted 1 deadbeef 1 1",
                     heard_valid, heard, heard_last, count);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({heard_valid, count} !== {1'b0, 3'd0})
            $display("[TB] FAIL single_drain: valid=%b count=%0d, wanted 0 0", heard_valid, count);
        else n_pass++;
    endtask

    task automatic test_dup();
        logic [1:0] exp_last = 2'b10;
        do_reset();
        @(negedge clk);
        say_valid = 1'b1; say = 32'h12345678; say_dup = 1'b1; heard_ready = 1'b1;
        @(negedge clk);
        say_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({heard_valid, heard, heard_last, count} !== {1'b1, 32'h12345678, exp_last[i], 3'd1})
                $display("[TB] FAIL dup_beat%0d: valid=%b heard=%h last=%b count=%0d, wanted 1 12345678 %b 1",
                         i, heard_valid, heard, heard_last, count, exp_last[i]);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({heard_valid, count} !== {1'b0, 3'd0})
            $display("[TB] FAIL dup_drain: valid=%b count=%0d, wanted 0 0", heard_valid, count);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [31:0] exp_heard [5] = '{1, 2, 3, 4, 5};
        logic [2:0]  exp_count [5] = '{4, 3, 3, 2, 1};
        logic        exp_ready [5] = '{0, 1, 1, 1, 1};
        do_reset();
        heard_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            say_valid = 1'b1; say = 32'(i); say_dup = 1'b0;
        end
        @(negedge clk);
        say = 32'd5;
        #1;
        n_checks++;
        if ({say_ready, count} !== {1'b0, 3'd4})
            $display("[TB] FAIL fill_full: say_ready=%b count=%0d, wanted 0 4", say_ready, count);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({say_ready, count, heard} !== {1'b0, 3'd4, 32'd1})
            $display("[TB] FAIL fill_hold: say_ready=%b count=%0d heard=%0d, wanted 0 4 1", say_ready, count, heard);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            heard_ready = 1'b1;
            say_valid = (i <= 1);
            #1;
            n_checks++;
            if ({heard_valid, heard, heard_last, count, say_ready} !==
                {1'b1, exp_heard[i], 1'b1, exp_count[i], exp_ready[i]})
                $display("[TB] FAIL fill_drain%0d: heard=%0d last=%b count=%0d say_ready=%b, wanted %0d 1 %0d %b",
                         i, heard, heard_last, count, say_ready, exp_heard[i], exp_count[i], exp_ready[i]);
            else n_pass++;
        end
        @(negedge clk);
        say_valid = 1'b0;
        #1;
        n_checks++;
        if ({heard_valid, count} !== {1'b0, 3'd0})
            $display("[TB] FAIL fill_empty: valid=%b count=%0d, wanted 0 0", heard_valid, count);
        else n_pass++;
    endtask

    task automatic test_random();
        int   sent = 0;
        int   cyc  = 0;
        bit   push;
        bit   hs;
        logic [31:0] d;
        bit   dup;
        do_reset();
        while ((sent < 20 || words != 0) && cyc < 600) begin
            @(negedge clk);
            d   = $urandom;
            dup = $urandom_range(0, 1);
            say_valid   = (sent < 20) && ($urandom_range(0, 3) != 0);
            say         = d;
            say_dup     = dup;
            heard_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_checks++;
            if ({heard_valid, say_ready, count} !== {words != 0, words < 4, 3'(words)} || count > 3'd4)
                $display("[TB] FAIL rand_status c%0d: valid=%b ready=%b count=%0d, wanted %b %b %0d",
                         cyc, heard_valid, say_ready, count, words != 0, words < 4, words);
            else n_pass++;
            if (words != 0) begin
                n_checks++;
                if ({heard_last, heard} !== q_beats[0])
                    $display("[TB] FAIL rand_data c%0d: heard=%h last=%b, wanted %h %b",
                             cyc, heard, heard_last, q_beats[0][31:0], q_beats[0][32]);
                else n_pass++;
            end
            push = say_valid && (words < 4);
            hs   = heard_ready && (words != 0);
            if (push) sent++;
            model_step(push, d, dup, hs);
            cyc++;
        end
        n_checks++;
        if (cyc >= 600)
            $display("[TB] FAIL rand_budget: sent=%0d words_left=%0d after %0d cycles, wanted all drained", sent, words, cyc);
        else n_pass++;
        @(negedge clk);
        say_valid = 1'b0;
    endtask

    task automatic test_reset_mid_dup();
        do_reset();
        heard_ready = 1'b0;
        @(negedge clk);
        say_valid = 1'b1; say = 32'hAAAA0001; say_dup = 1'b1;
        @(negedge clk);
        say = 32'hBBBB0002; say_dup = 1'b0;
        @(negedge clk);
        say_valid = 1'b0;
        heard_ready = 1'b1;
        #1;
        n_checks++;
        if ({heard, heard_last, count} !== {32'hAAAA0001, 1'b0, 3'd2})
            $display("[TB] FAIL middup_first: heard=%h last=%b count=%0d, wanted aaaa0001 0 2", heard, heard_last, count);
        else n_pass++;
        @(negedge clk);
        heard_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({heard_valid, count, say_ready} !== {1'b0, 3'd0, 1'b1})
            $display("[TB] FAIL middup_rst: valid=%b count=%0d ready=%b, wanted 0 0 1", heard_valid, count, say_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        say_valid = 1'b1; say = 32'hCCCC0003; say_dup = 1'b0;
        @(negedge clk);
        say_valid = 1'b0;
        #1;
        n_checks++;
        if ({heard_valid, heard, heard_last, count} !== {1'b1, 32'hCCCC0003, 1'b1, 3'd1})
            $display("[TB] FAIL middup_after: valid=%b heard=%h last=%b count=%0d, wanted 1 cccc0003 1 1",
                     heard_valid, heard, heard_last, count);
        else n_pass++;
        q_beats.delete();
        words = 0;
    endtask

    task automatic test_sweep();
        logic [7:0] exp8 [2] = '{8'hFF, 8'h00};
        do_reset();
        @(negedge clk);
        s8_valid = 1'b1; s8_say = 8'hFF; s8_dup = 1'b0; h8_ready = 1'b0;
        @(negedge clk);
        s8_say = 8'h00;
        @(negedge clk);
        s8_say = 8'h5A;
        #1;
        n_checks++;
        if ({s8_ready, c8_count, h8_valid} !== {1'b0, 2'd2, 1'b1})
            $display("[TB] FAIL sweep_full: ready=%b count=%0d valid=%b, wanted 0 2 1", s8_ready, c8_count, h8_valid);
        else n_pass++;
        @(negedge clk);
        s8_valid = 1'b0;
        h8_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({h8_valid, h8_heard, h8_last} !== {1'b1, exp8[i], 1'b1})
                $display("[TB] FAIL sweep_out%0d: valid=%b heard=%h last=%b, wanted 1 %h 1",
                         i, h8_valid, h8_heard, h8_last, exp8[i]);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({h8_valid, c8_count} !== {1'b0, 2'd0})
            $display("[TB] FAIL sweep_empty: valid=%b count=%0d, wanted 0 0", h8_valid, c8_count);
        else n_pass++;
        h8_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        say_valid = 1'b0; heard_ready = 1'b0; say = '0; say_dup = 1'b0;
        s8_valid = 1'b0; h8_ready = 1'b0; s8_say = '0; s8_dup = 1'b0;
        test_reset();
        test_single();
        test_dup();
        test_fill();
        test_random();
        test_reset_mid_dup();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/echo_buffered.md
Name: echo_buffered

Overview:
- Parametrised, buffered successor to the combinational echo block: words offered on the "say" channel are stored in a DEPTH-entry FIFO and returned on the "heard" channel under valid/ready flow control.
- Per-word duplicate mode: a word enqueued with say_dup=1 is echoed twice back-to-back before it is popped.
- Sits between the host request portal and the indication portal in echo-style examples and tests.

Parameters:
- WIDTH, 32, data width of say/heard.
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, $clog2(DEPTH+1), derived localparam; width of count. Not overridable.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- say_valid  input  1  producer has a word.
- say_ready  output  1  FIFO can accept; equals (count < DEPTH).
- say  input  WIDTH  word to echo.
- say_dup  input  1  sampled with say; 1 = echo this word twice.
- heard_valid  output  1  head word is available; equals (count != 0).
- heard_ready  input  1  consumer accepts.
- heard  output  WIDTH  head word data.
- heard_last  output  1  1 on the final (or only) copy of the head word.
- count  output  CNT_W  number of stored words, 0..DEPTH.

Behaviour:
- Reset (async assert, sync-safe release):
  - wr_ptr=0, rd_ptr=0, count=0, FSM=ST_FIRST.
  - Outputs during and after reset: heard_valid=0, say_ready=1, count=0.
  - heard_last and heard are don't-care while heard_valid=0; storage is not reset.
- Enqueue:
  - Fires on say_valid && say_ready.
  - Writes {say_dup, say} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Dequeue handshake: heard_valid && heard_ready.
- Output FSM:
  - ST_FIRST, head dup=0: heard_last=1; handshake pops the entry and stays in ST_FIRST.
  - ST_FIRST, head dup=1: heard_last=0; handshake moves to ST_SECOND without popping.
  - ST_SECOND: heard_last=1, heard = same word; handshake pops and returns to ST_FIRST.
- Latency and bypass:
  - Word enqueued at edge N is visible with heard_valid=1 after edge N.
  - No empty-to-output combinational bypass; minimum latency is 1 cycle.
- Count update:
  - count +1 on enqueue only; -1 on pop only.
  - Unchanged on simultaneous enqueue+pop, and on the non-popping first handshake of a dup word.
- Full: say_ready=0; say_valid is ignored. No full-and-pop bypass, so say_ready rises the cycle after the pop.
- Empty: heard_valid=0; heard_ready is ignored; FSM stays in ST_FIRST.
- Simultaneous enqueue and pop when 0<count<DEPTH: both occur and count is unchanged.
- Pointer wrap: rd_ptr and wr_ptr wrap independently; full vs. empty is decided by count, not by pointer equality.
- Stability: while heard_valid=1 && heard_ready=0, heard and heard_last must not change.
- Producer protocol: the producer holds say and say_dup stable while say_valid=1 && say_ready=0. The block does not check this.
- Reset mid-operation: all stored words and any pending second copy are discarded immediately; no partial output after release.

Decomposition:
- Package echo_pkg:
  - state constants ST_FIRST=1'b0, ST_SECOND=1'b1.
  - a clog2 helper function if the tool lacks $clog2.
- Sub-module echo_fifo_mem: DEPTH x (WIDTH+1) register array with write port and combinational read at rd_ptr.
- Pointers, count, FSM and handshake logic stay in echo_buffered.

Test Plan:
- Single word: reset, send say=32'hDEADBEEF with dup=0, heard_ready=1 → heard_valid rises 1 cycle after accept; heard=DEADBEEF, heard_last=1; count returns to 0.
- Duplicate: send 32'h12345678 with dup=1, heard_ready=1 → two consecutive heard beats of 12345678 with heard_last=0 then 1; count drops only after the second beat.
- Fill and backpressure: heard_ready=0, send 1,2,3,4 (DEPTH=4) → say_ready=0 with count=4; a 5th word is held. Then heard_ready=1 → output 1,2,3,4 in order; say_ready rises the cycle after the first pop.
- Wrap plus concurrency: 20 random words with random dup, random say_valid/heard_ready, DEPTH=4 → scoreboard matches order and dup expansion; heard stable during stalls; count never exceeds 4.
- Reset mid-dup: enqueue A(dup=1), B; accept the first copy of A, then assert rst → heard_valid=0 and count=0 immediately. After release, send C → the next heard is C with heard_last=1.
- Width/depth sweep: WIDTH=8, DEPTH=2, send 8'hFF then 8'h00 → correct values; count width=2; full at count=2.
